cc1200_apb_cfg_sched: RTL

//  APB master that owns the CC1200SPI_Top register port. After reset it replays a fixed boot table of register writes.

---
 rtl/cc1200_apb_cfg_sched_if.sv | 11 +
 rtl/cc1200_apb_cfg_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cc1200_apb_cfg_sched_if.sv
// cc1200_apb_cfg_sched_if: APB bus between the config scheduler (master) and CC1200SPI_Top (slave)
interface cc1200_apb_cfg_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [DATA_W-1:0] pwdata, prdata;
  modport master(output paddr, psel, penable, pwrite, pwdata, input prdata, pready, pslverr);
  modport slave(input paddr, psel, penable, pwrite, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/cc1200_apb_cfg_sched.sv
// cc1200_apb_cfg_sched: APB master replaying the CC1200 boot table, then serving single host reads/writes (CFG_READBACK_EN adds boot readback verify)
module cc1200_apb_cfg_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int BOOT_N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reboot,
  output logic              boot_done,
  output logic              boot_err,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  cc1200_apb_cfg_sched_if.master m
);
  typedef enum logic [2:0] {S_RST, S_BSETUP, S_BACCESS, S_BRSETUP, S_BRACCESS, S_IDLE, S_SETUP, S_ACCESS} state_t;
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, boot_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d, boot_data;
  logic              write_q, write_d, boot_done_q, boot_done_d, boot_err_q, boot_err_d;
  logic              reboot_q, reboot_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic              acc, fin, fail, bad, last, boot_st;
  assign acc  = state_q inside {S_BACCESS, S_BRACCESS, S_ACCESS};
  assign fin  = acc && (m.pready || cnt_q == 8'(TIMEOUT - 1));
  assign fail = m.pslverr || !m.pready;
  assign bad  = fail || m.prdata != boot_data;
  assign last = idx_q == 2'(BOOT_N - 1);
  assign boot_st = state_q inside {S_BSETUP, S_BACCESS, S_BRSETUP, S_BRACCESS};
  // fixed boot table indexed by the current entry
  always_comb begin
    boot_addr = idx_q == 2'd0 ? ADDR_W'('h14) : idx_q == 2'd1 ? ADDR_W'('h24) : idx_q == 2'd2 ? ADDR_W'('h2C) : '0;
    boot_data = idx_q == 2'd0 ? DATA_W'('h4) : idx_q == 2'd3 ? DATA_W'('h2) : DATA_W'('h12);
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RST;
    else state_q <= state_d;
  end
  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      boot_done_q <= 1'b0;
      boot_err_q <= 1'b0;
      reboot_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      boot_done_q <= boot_done_d;
      boot_err_q <= boot_err_d;
      reboot_q <= reboot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  // next state: boot sequencing, host arbitration, timeout and response capture
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = acc && !fin ? cnt_q + 8'd1 : '0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    boot_done_d = boot_done_q;
    boot_err_d = boot_err_q;
    reboot_d = reboot_q || reboot;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_RST: state_d = S_BSETUP;
      S_BSETUP: state_d = S_BACCESS;
      S_BACCESS: if (fin) begin
`ifdef CFG_READBACK_EN
        state_d = fail ? S_IDLE : S_BRSETUP;
        boot_done_d = fail;
        boot_err_d = fail;
`else
        state_d = fail || last ? S_IDLE : S_BSETUP;
        idx_d = idx_q + 2'd1;
        boot_done_d = fail || last;
        boot_err_d = fail;
`endif
      end
      S_BRSETUP: state_d = S_BRACCESS;
      S_BRACCESS: if (fin) begin
        state_d = bad || last ? S_IDLE : S_BSETUP;
        idx_d = idx_q + 2'd1;
        boot_done_d = bad || last;
        boot_err_d = bad;
      end
      S_IDLE: if (reboot_q || reboot) begin
        state_d = S_BSETUP;
        idx_d = '0;
        boot_done_d = 1'b0;
        boot_err_d = 1'b0;
        reboot_d = 1'b0;
      end else if (req_valid && boot_done_q) begin
        state_d = S_SETUP;
        addr_d = req_addr;
        wdata_d = req_wdata;
        write_d = req_write;
      end
      S_SETUP: state_d = S_ACCESS;
      default: if (fin) begin
        state_d = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d = fail;
        rsp_rdata_d = fail || write_q ? '0 : m.prdata;
      end
    endcase
  end
  // APB and host-side outputs decoded from the current state
  always_comb begin
    m.psel = boot_st || state_q inside {S_SETUP, S_ACCESS};
    m.penable = acc;
    m.pwrite = state_q inside {S_BSETUP, S_BACCESS} || (write_q && state_q inside {S_SETUP, S_ACCESS});
    m.paddr = !m.psel ? '0 : boot_st ? boot_addr : addr_q;
    m.pwdata = !m.pwrite ? '0 : boot_st ? boot_data : wdata_q;
    req_ready = state_q == S_IDLE && boot_done_q && !reboot_q && !reboot;
  end
  assign boot_done = boot_done_q;
  assign boot_err = boot_err_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
endmodule
